// File: rtl/handle_turn_action.sv
// handle_turn_action: turn-gated handshake for GameControl table actions.
// Each of NUM_ACT channels (reset table, draw card, end turn, ...) can be
// started locally by a rising edge on act_raw while it is our turn, or
// completed directly when the peer board reports the matching message type.
// A local start sends one interboard message, then waits for inter_ready.
// If inter_ready does not arrive within TIMEOUT cycles, the send is abandoned.
//
// Optional build macro HANDLE_TURN_ACTION_RETRY_EN: when it is defined, a
// timed-out send is re-issued up to MAX_RETRY times. Only after that does
// timeout_err pulse.

`ifndef P1
`define P1 0
`endif
`ifndef P2
`define P2 1
`endif
`ifndef GAME_P1_WAIT_IN
`define GAME_P1_WAIT_IN 4'd1
`endif
`ifndef GAME_P1_MOVE
`define GAME_P1_MOVE 4'd2
`endif
`ifndef GAME_P1_SHIFT
`define GAME_P1_SHIFT 4'd3
`endif
`ifndef GAME_P2_WAIT_IN
`define GAME_P2_WAIT_IN 4'd4
`endif
`ifndef GAME_P2_MOVE
`define GAME_P2_MOVE 4'd5
`endif
`ifndef GAME_P2_SHIFT
`define GAME_P2_SHIFT 4'd6
`endif

module handle_turn_action #(
    parameter int          PLAYER        = 0,
    parameter int          NUM_ACT       = 3,
    parameter logic [31:0] ACT_MSG_TYPES = 32'h0000_0987,
    parameter int          TIMEOUT       = 1000000,
    parameter int          MAX_RETRY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               interboard_rst,
    input  logic [NUM_ACT-1:0] act_raw,
    input  logic [3:0]         cur_game_state,
    input  logic               inter_ready,
    input  logic               interboard_en,
    input  logic [3:0]         interboard_msg_type,
    output logic [NUM_ACT-1:0] act_done,
    output logic               act_remote,
    output logic               busy,
    output logic               timeout_err,
    output logic               ctrl_en,
    output logic [3:0]         ctrl_msg_type,
    output logic               ctrl_move_dir,
    output logic [4:0]         ctrl_block_x,
    output logic [2:0]         ctrl_block_y,
    output logic [5:0]         ctrl_card,
    output logic [2:0]         ctrl_sel_len
);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_ACT < 1 || NUM_ACT > 8) begin : g_bad_num_act
        $error("handle_turn_action: NUM_ACT must be 1..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("handle_turn_action: TIMEOUT must be >= 2");
    end
    if (MAX_RETRY < 0) begin : g_bad_retry
        $error("handle_turn_action: MAX_RETRY must be >= 0");
    end

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

`ifdef HANDLE_TURN_ACTION_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_FIN
    } state_t;

    state_t             state;
    logic [2:0]         idx;
    logic [NUM_ACT-1:0] act_raw_q;
    logic [CNT_W-1:0]   to_cnt;
`ifdef HANDLE_TURN_ACTION_RETRY_EN
    logic [RETRY_W-1:0] retry_cnt;
`endif

    logic [NUM_ACT-1:0] req;
    logic [NUM_ACT-1:0] remote_match;
    logic               remote_hit;
    logic [2:0]         remote_idx;
    logic [2:0]         local_idx;
    logic               player_correct;

    // Message type assigned to channel i (0 for channels that do not exist).
    function automatic logic [3:0] msg_type_of(input logic [2:0] i);
        logic [3:0] t;
        t = '0;
        for (int k = 0; k < NUM_ACT; k++) begin
            if (i == 3'(k)) t = ACT_MSG_TYPES[4*k +: 4];
        end
        return t;
    endfunction

    // One-hot completion vector for channel i.
    function automatic logic [NUM_ACT-1:0] one_hot(input logic [2:0] i);
        logic [NUM_ACT-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_ACT; k++) begin
            if (i == 3'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_idx(input logic [NUM_ACT-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int k = NUM_ACT - 1; k >= 0; k--) begin
            if (v[k]) r = 3'(k);
        end
        return r;
    endfunction

    // Rising-edge requests and the lowest-indexed winner.
    always_comb begin
        req       = act_raw & ~act_raw_q;
        local_idx = lowest_idx(req);
    end

    // Peer message decode: the lowest channel whose type matches wins.
    always_comb begin
        remote_match = '0;
        for (int k = 0; k < NUM_ACT; k++) begin
            remote_match[k] = (interboard_msg_type == ACT_MSG_TYPES[4*k +: 4]);
        end
        remote_hit = interboard_en && (|remote_match);
        remote_idx = lowest_idx(remote_match);
    end

    // Our turn: the owning player's WAIT_IN, MOVE or SHIFT game state.
    always_comb begin
        player_correct = 1'b0;
        if (PLAYER == `P1) begin
            player_correct = (cur_game_state == `GAME_P1_WAIT_IN) ||
                             (cur_game_state == `GAME_P1_MOVE)    ||
                             (cur_game_state == `GAME_P1_SHIFT);
        end else begin
            player_correct = (cur_game_state == `GAME_P2_WAIT_IN) ||
                             (cur_game_state == `GAME_P2_MOVE)    ||
                             (cur_game_state == `GAME_P2_SHIFT);
        end
    end

    // Action sequencer: latches the winning channel, runs the send/wait
    // handshake, and registers every output alongside the state.
    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            act_raw_q     <= '0;
            to_cnt        <= '0;
`ifdef HANDLE_TURN_ACTION_RETRY_EN
            retry_cnt     <= '0;
`endif
            act_done      <= '0;
            act_remote    <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_msg_type <= '0;
        end else begin
            act_raw_q   <= act_raw;
            act_done    <= '0;
            timeout_err <= 1'b0;
            ctrl_en     <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef HANDLE_TURN_ACTION_RETRY_EN
                    retry_cnt <= '0;
`endif
                    if (remote_hit) begin
                        // The peer already performed the action; only report completion.
                        idx        <= remote_idx;
                        act_remote <= 1'b1;
                        busy       <= 1'b1;
                        act_done   <= one_hot(remote_idx);
                        state      <= S_FIN;
                    end else if (player_correct && (|req)) begin
                        idx           <= local_idx;
                        act_remote    <= 1'b0;
                        busy          <= 1'b1;
                        ctrl_en       <= 1'b1;
                        ctrl_msg_type <= msg_type_of(local_idx);
                        state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    // inter_ready seen here belongs to an older message; ignore it.
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (inter_ready) begin
                        act_done <= one_hot(idx);
                        state    <= S_FIN;
                    end else if (to_cnt == TO_LAST) begin
`ifdef HANDLE_TURN_ACTION_RETRY_EN
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            ctrl_en   <= 1'b1;
                            state     <= S_SEND;
                        end else begin
                            timeout_err   <= 1'b1;
                            busy          <= 1'b0;
                            act_remote    <= 1'b0;
                            ctrl_msg_type <= '0;
                            state         <= S_IDLE;
                        end
`else
                        timeout_err   <= 1'b1;
                        busy          <= 1'b0;
                        act_remote    <= 1'b0;
                        ctrl_msg_type <= '0;
                        state         <= S_IDLE;
`endif
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    busy          <= 1'b0;
                    act_remote    <= 1'b0;
                    ctrl_msg_type <= '0;
                    state         <= S_IDLE;
                end
                default: begin
                    busy          <= 1'b0;
                    act_remote    <= 1'b0;
                    ctrl_msg_type <= '0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    // Table actions carry no move, block, card or selection payload.
    assign ctrl_move_dir = 1'b0;
    assign ctrl_block_x  = '0;
    assign ctrl_block_y  = '0;
    assign ctrl_card     = '0;
    assign ctrl_sel_len  = '0;

endmodule
